// File: rtl/instr_decode.sv
// Decode stage: registers opcode, register selects, immediate and control
// flags from a 16-bit instruction word behind a valid/ready handshake.
// It also tracks a sticky illegal-instruction flag and an accept counter.
module instr_decode (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic        i_flush,
    input  logic [15:0] i_instr,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_ready,
    output logic        o_valid,
    output logic [2:0]  o_selA,
    output logic [2:0]  o_selB,
    output logic [2:0]  o_selD,
    output logic [3:0]  o_aluop,
    output logic [15:0] o_imm,
    output logic        o_regwe,
    output logic        o_illegal,
    output logic        o_err,
    output logic [15:0] o_icount
);

    logic        valid_q,   valid_d;
    logic [2:0]  sela_q,    sela_d;
    logic [2:0]  selb_q,    selb_d;
    logic [2:0]  seld_q,    seld_d;
    logic [3:0]  aluop_q,   aluop_d;
    logic [15:0] imm_q,     imm_d;
    logic        regwe_q,   regwe_d;
    logic        illegal_q, illegal_d;
    logic        err_q,     err_d;
    logic [15:0] icount_q,  icount_d;

    logic [3:0]  op;
    logic [7:0]  imm8;
    logic        dec_regwe;
    logic        dec_illegal;
    logic [15:0] dec_imm;
    logic        accept;

    assign op   = i_instr[15:12];
    assign imm8 = i_instr[7:0];

    // Reset holds the stage closed so nothing is accepted while it is asserted.
    assign o_ready = i_en & ~i_rst & (~valid_q | i_ready);
    assign accept  = i_en & i_valid & o_ready & ~i_flush;

    // Combinational decode of the incoming word.
    always_comb begin
        dec_regwe   = 1'b1;
        dec_illegal = 1'b0;
        dec_imm     = 16'h0000;
        case (op)
            4'h7, 4'hC, 4'hD: dec_regwe = 1'b0;
            4'hE, 4'hF: begin
                dec_regwe   = 1'b0;
                dec_illegal = 1'b1;
            end
            default: dec_regwe = 1'b1;
        endcase
        case (op)
            4'h8:       dec_imm = {8'h00, imm8};
            4'hC, 4'hD: dec_imm = {{8{imm8[7]}}, imm8};
            4'hA, 4'hB: dec_imm = {12'h000, i_instr[3:0]};
            default:    dec_imm = 16'h0000;
        endcase
    end

    // Next-state: flush beats accept, accept beats drain; disable freezes all.
    always_comb begin
        valid_d   = valid_q;
        sela_d    = sela_q;
        selb_d    = selb_q;
        seld_d    = seld_q;
        aluop_d   = aluop_q;
        imm_d     = imm_q;
        regwe_d   = regwe_q;
        illegal_d = illegal_q;
        err_d     = err_q;
        icount_d  = icount_q;
        if (i_en) begin
            if (i_flush) begin
                valid_d = 1'b0;
            end else if (accept) begin
                valid_d   = 1'b1;
                seld_d    = i_instr[11:9];
                sela_d    = i_instr[8:6];
                selb_d    = i_instr[5:3];
                aluop_d   = op;
                imm_d     = dec_imm;
                regwe_d   = dec_regwe;
                illegal_d = dec_illegal;
                err_d     = err_q | dec_illegal;
                icount_d  = icount_q + 16'd1;
            end else if (valid_q && i_ready) begin
                valid_d = 1'b0;
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q   <= 1'b0;
            sela_q    <= 3'd0;
            selb_q    <= 3'd0;
            seld_q    <= 3'd0;
            aluop_q   <= 4'd0;
            imm_q     <= 16'h0000;
            regwe_q   <= 1'b0;
            illegal_q <= 1'b0;
            err_q     <= 1'b0;
            icount_q  <= 16'h0000;
        end else begin
            valid_q   <= valid_d;
            sela_q    <= sela_d;
            selb_q    <= selb_d;
            seld_q    <= seld_d;
            aluop_q   <= aluop_d;
            imm_q     <= imm_d;
            regwe_q   <= regwe_d;
            illegal_q <= illegal_d;
            err_q     <= err_d;
            icount_q  <= icount_d;
        end
    end

    assign o_valid   = valid_q;
    assign o_selA    = sela_q;
    assign o_selB    = selb_q;
    assign o_selD    = seld_q;
    assign o_aluop   = aluop_q;
    assign o_imm     = imm_q;
    assign o_regwe   = regwe_q;
    assign o_illegal = illegal_q;
    assign o_err     = err_q;
    assign o_icount  = icount_q;

endmodule

// File: tb/tb_instr_decode.sv
// Directed bench for instr_decode with hand-computed expectations.
module tb_instr_decode;

    logic        i_clk, i_rst, i_en, i_flush, i_valid, i_ready;
    logic [15:0] i_instr;
    logic        o_ready, o_valid, o_regwe, o_illegal, o_err;
    logic [2:0]  o_selA, o_selB, o_selD;
    logic [3:0]  o_aluop;
    logic [15:0] o_imm, o_icount;

    int checks = 0;
    int errors = 0;

    instr_decode dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_flush(i_flush),
        .i_instr(i_instr), .i_valid(i_valid), .o_ready(o_ready),
        .i_ready(i_ready), .o_valid(o_valid), .o_selA(o_selA),
        .o_selB(o_selB), .o_selD(o_selD), .o_aluop(o_aluop),
        .o_imm(o_imm), .o_regwe(o_regwe), .o_illegal(o_illegal),
        .o_err(o_err), .o_icount(o_icount)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".valid"},   16'(o_valid),   16'h0);
        chk({tag, ".selA"},    16'(o_selA),    16'h0);
        chk({tag, ".selB"},    16'(o_selB),    16'h0);
        chk({tag, ".selD"},    16'(o_selD),    16'h0);
        chk({tag, ".aluop"},   16'(o_aluop),   16'h0);
        chk({tag, ".imm"},     o_imm,          16'h0);
        chk({tag, ".regwe"},   16'(o_regwe),   16'h0);
        chk({tag, ".illegal"}, 16'(o_illegal), 16'h0);
        chk({tag, ".err"},     16'(o_err),     16'h0);
        chk({tag, ".icount"},  o_icount,       16'h0);
    endtask

    initial begin
        i_rst = 1'b1; i_en = 1'b1; i_flush = 1'b0; i_valid = 1'b0;
        i_ready = 1'b1; i_instr = 16'h0000;
        tick();
        chk_zero("reset");
        chk("reset.ready", 16'(o_ready), 16'h0);
        i_rst = 1'b0;
        #1;
        chk("post_reset.ready", 16'(o_ready), 16'h1);

        // First accept: 0458 -> rD=2 rA=1 rB=3
        i_valid = 1'b1; i_instr = 16'h0458;
        tick();
        chk("i0458.valid",  16'(o_valid), 16'h1);
        chk("i0458.selD",   16'(o_selD),  16'h2);
        chk("i0458.selA",   16'(o_selA),  16'h1);
        chk("i0458.selB",   16'(o_selB),  16'h3);
        chk("i0458.aluop",  16'(o_aluop), 16'h0);
        chk("i0458.regwe",  16'(o_regwe), 16'h1);
        chk("i0458.imm",    o_imm,        16'h0000);
        chk("i0458.icount", o_icount,     16'h1);

        // LOAD: zero-extended imm8
        i_instr = 16'h86F0;
        tick();
        chk("load.imm",    o_imm,        16'h00F0);
        chk("load.selD",   16'(o_selD),  16'h3);
        chk("load.selB",   16'(o_selB),  16'h6);
        chk("load.regwe",  16'(o_regwe), 16'h1);
        chk("load.aluop",  16'(o_aluop), 16'h8);
        chk("load.icount", o_icount,     16'h2);

        // JUMP: sign-extended imm8
        i_instr = 16'hC0FE;
        tick();
        chk("jump.imm",     o_imm,          16'hFFFE);
        chk("jump.regwe",   16'(o_regwe),   16'h0);
        chk("jump.illegal", 16'(o_illegal), 16'h0);
        chk("jump.icount",  o_icount,       16'h3);

        // Backpressure for 3 cycles with a new instruction offered
        i_ready = 1'b0; i_instr = 16'h1234;
        #1;
        chk("stall.ready", 16'(o_ready), 16'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall.valid",  16'(o_valid), 16'h1);
            chk("stall.aluop",  16'(o_aluop), 16'hC);
            chk("stall.imm",    o_imm,        16'hFFFE);
            chk("stall.ready",  16'(o_ready), 16'h0);
            chk("stall.icount", o_icount,     16'h3);
        end
        i_ready = 1'b1;
        #1;
        chk("unstall.ready", 16'(o_ready), 16'h1);
        tick();
        // 1234 -> rD=1 rA=0 rB=6, loaded with no bubble
        chk("replace.valid",  16'(o_valid), 16'h1);
        chk("replace.aluop",  16'(o_aluop), 16'h1);
        chk("replace.selD",   16'(o_selD),  16'h1);
        chk("replace.selA",   16'(o_selA),  16'h0);
        chk("replace.selB",   16'(o_selB),  16'h6);
        chk("replace.imm",    o_imm,        16'h0000);
        chk("replace.icount", o_icount,     16'h4);

        // Illegal opcode sets sticky error
        i_instr = 16'hE000;
        tick();
        chk("ill.illegal", 16'(o_illegal), 16'h1);
        chk("ill.regwe",   16'(o_regwe),   16'h0);
        chk("ill.imm",     o_imm,          16'h0000);
        chk("ill.err",     16'(o_err),     16'h1);
        chk("ill.icount",  o_icount,       16'h5);

        // 2A5F -> rD=5 rA=1 rB=3, legal
        i_instr = 16'h2A5F;
        tick();
        chk("legal.illegal", 16'(o_illegal), 16'h0);
        chk("legal.err",     16'(o_err),     16'h1);
        chk("legal.regwe",   16'(o_regwe),   16'h1);
        chk("legal.selD",    16'(o_selD),    16'h5);
        chk("legal.selA",    16'(o_selA),    16'h1);
        chk("legal.selB",    16'(o_selB),    16'h3);
        chk("legal.imm",     o_imm,          16'h0000);

        // Shift immediate from instr[3:0]
        i_instr = 16'hA037;
        tick();
        chk("shift.imm",   o_imm,        16'h0007);
        chk("shift.aluop", 16'(o_aluop), 16'hA);
        chk("shift.regwe", 16'(o_regwe), 16'h1);

        // Opcode 7 has no writeback
        i_instr = 16'h7000;
        tick();
        chk("op7.regwe",  16'(o_regwe), 16'h0);
        chk("op7.icount", o_icount,     16'h8);

        // Drain: valid drops, fields hold
        i_valid = 1'b0;
        tick();
        chk("drain.valid",  16'(o_valid), 16'h0);
        chk("drain.aluop",  16'(o_aluop), 16'h7);
        chk("drain.icount", o_icount,     16'h8);

        // Flush with valid high blocks accept and squashes held instruction
        i_valid = 1'b1; i_instr = 16'h1234;
        tick();
        chk("preflush.valid", 16'(o_valid), 16'h1);
        chk("preflush.icount", o_icount,    16'h9);
        i_flush = 1'b1; i_instr = 16'h2A5F;
        tick();
        chk("flush.valid",  16'(o_valid), 16'h0);
        chk("flush.icount", o_icount,     16'h9);
        chk("flush.aluop",  16'(o_aluop), 16'h1);
        i_flush = 1'b0;

        // Disable for 5 cycles: everything frozen, flush ignored
        i_instr = 16'h86F0;
        tick();
        chk("preen.valid",  16'(o_valid), 16'h1);
        chk("preen.icount", o_icount,     16'hA);
        i_en = 1'b0; i_flush = 1'b1; i_instr = 16'hE000;
        #1;
        chk("dis.ready", 16'(o_ready), 16'h0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("dis.valid",  16'(o_valid), 16'h1);
            chk("dis.aluop",  16'(o_aluop), 16'h8);
            chk("dis.imm",    o_imm,        16'h00F0);
            chk("dis.selD",   16'(o_selD),  16'h3);
            chk("dis.err",    16'(o_err),   16'h1);
            chk("dis.icount", o_icount,     16'hA);
            chk("dis.ready",  16'(o_ready), 16'h0);
        end
        i_en = 1'b1; i_flush = 1'b0;

        // Async reset mid-handshake, before the next edge
        i_ready = 1'b0;
        #1;
        i_rst = 1'b1;
        #1;
        chk_zero("arst1");
        chk("arst1.ready", 16'(o_ready), 16'h0);
        tick();
        i_rst = 1'b0; i_ready = 1'b1; i_valid = 1'b1; i_instr = 16'h0458;
        tick();
        chk("after_rst.icount", o_icount,     16'h1);
        chk("after_rst.valid",  16'(o_valid), 16'h1);
        chk("after_rst.err",    16'(o_err),   16'h0);

        // Run counter to 16'hFFFF, then wrap
        for (int k = 0; k < 65534; k++) tick();
        chk("cnt.ffff", o_icount, 16'hFFFF);
        tick();
        chk("cnt.wrap", o_icount, 16'h0000);
        tick();
        chk("cnt.one",  o_icount, 16'h0001);

        #1;
        i_rst = 1'b1;
        #1;
        chk_zero("arst2");
        i_rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_decode.md
INSTR_DECODE -- requirements
Module: instr_decode

Interface
REQ-001 SHALL have port i_clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port i_rst, input, 1, reset, asynchronous and active-high.
REQ-003 SHALL have port i_en, input, 1, stage enable; low freezes all state.
REQ-004 SHALL have port i_flush, input, 1, synchronous squash of the held instruction.
REQ-005 SHALL have port i_instr, input, 16, fetched instruction word.
REQ-006 SHALL have port i_valid, input, 1, upstream has an instruction on i_instr.
REQ-007 SHALL have port o_ready, output, 1, stage can accept an instruction this cycle.
REQ-008 SHALL have port i_ready, input, 1, downstream (reg_file/execute) accepts o_* this cycle.
REQ-009 SHALL have port o_valid, output, 1, decoded outputs hold a live instruction.
REQ-010 SHALL have ports o_selA, o_selB, o_selD, output, 3 each, register-file read A / read B / write selects.
REQ-011 SHALL have port o_aluop, output, 4, opcode passed to execute.
REQ-012 SHALL have port o_imm, output, 16, decoded immediate.
REQ-013 SHALL have port o_regwe, output, 1, writeback enable for o_selD.
REQ-014 SHALL have port o_illegal, output, 1, held instruction is illegal.
REQ-015 SHALL have port o_err, output, 1, sticky illegal-instruction flag.
REQ-016 SHALL have port o_icount, output, 16, count of accepted instructions.

Function
REQ-017 Field map SHALL be: opcode [15:12], rD [11:9], rA [8:6], rB [5:3], imm8 [7:0].
REQ-018 o_ready SHALL equal i_en & (~o_valid | i_ready), combinationally.
REQ-019 Accept SHALL occur when i_en & i_valid & o_ready & ~i_flush; on accept, all o_* decode fields register from i_instr and o_valid=1 next cycle (latency 1).
REQ-020 When i_en & o_valid & i_ready & no accept, o_valid SHALL go 0 next cycle; decode fields hold.
REQ-021 When o_valid & ~i_ready, o_* SHALL hold stable (no overwrite) regardless of i_valid.
REQ-022 i_flush & i_en SHALL clear o_valid next cycle and block accept that cycle; flush has priority over accept and drain.
REQ-023 i_en=0 SHALL hold o_valid, all decode fields, o_err, o_icount unchanged; flush ignored.
REQ-024 o_selD/o_selA/o_selB SHALL be raw fields rD/rA/rB for every opcode.
REQ-025 o_aluop SHALL equal opcode.
REQ-026 o_regwe SHALL be 1 for opcodes 0x0-0x6 and 0x8-0xB; 0 for 0x7, 0xC, 0xD, 0xE, 0xF.
REQ-027 o_imm SHALL be {8'h00, imm8} for 0x8 (LOAD); sign-extended imm8 for 0xC/0xD (JUMP/JUMPEQ); {12'h000, instr[3:0]} for 0xA/0xB (shifts); 16'h0000 otherwise.
REQ-028 Opcodes 0xE and 0xF SHALL be illegal: o_illegal=1, o_regwe=0, o_imm=0.
REQ-029 o_err SHALL set on accept of an illegal instruction and clear only on reset.
REQ-030 o_icount SHALL increment by 1 per accept, modulo 2^16 (16'hFFFF -> 16'h0000); flushed instructions remain counted.
REQ-031 Simultaneous drain and accept SHALL replace the held instruction with no bubble (o_valid stays 1).

Reset
REQ-032 i_rst=1 SHALL immediately, regardless of i_clk, force o_valid=0, o_selA=o_selB=o_selD=0, o_aluop=0, o_imm=0, o_regwe=0, o_illegal=0, o_err=0, o_icount=0.
REQ-033 Reset asserted mid-handshake SHALL discard the held instruction; first accept after deassertion is counted as 1.
REQ-034 During reset o_ready SHALL be 0.

Verification
REQ-035 Reset, i_en=1, i_ready=1, i_instr=16'h0458 valid one cycle -> next cycle o_valid=1, selD=2, selA=1, selB=3, aluop=0, regwe=1, icount=1.
REQ-036 i_instr=16'h86F0 (LOAD r3) accepted -> o_imm=16'h00F0, selD=3, regwe=1; i_instr=16'hC0FE -> o_imm=16'hFFFE, regwe=0.
REQ-037 o_valid=1, i_ready=0 for 3 cycles with new i_valid -> o_ready=0, o_* unchanged; i_ready=1 -> next instruction loaded without bubble.
REQ-038 i_instr=16'hE000 accepted -> o_illegal=1, regwe=0, o_err=1; following legal instruction -> o_illegal=0, o_err remains 1.
REQ-039 i_flush with i_valid high -> o_valid=0 next cycle, icount unchanged; i_en=0 for 5 cycles -> all outputs frozen, o_ready=0.
REQ-040 Preload 16'hFFFF accepts -> icount=16'hFFFF; one more accept -> 16'h0000; async i_rst mid-cycle -> all outputs 0 before next edge.
